swnet_pipe: RTL
===============

# swnet_pipe

Parametrised, pipelined N×N butterfly switch network built from log2(N) stages of 2×2 pass/swap elements. Each stage is registered, and beats move with a valid/ready handshake and backpressure. Routing selects are loaded through a configuration port and travel with each beat, so reconfiguring never corrupts beats already in flight. The block replaces the fixed-size combinational 4-port switch wherever lanes are permuted between a producer and a consumer.

## Interface
**Parameters**
- LOG2N, default 2: log2 of the lane count; N = 2**LOG2N; legal range 1..5.
- W, default 8: data width per lane.

**Ports**
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- cfg_valid  in  1  load cfg_sel into the active select register.
- cfg_sel  in  LOG2N*N/2  element selects; bit s*(N/2)+e drives element e of stage s.
- in_valid  in  1  input beat present.
- in_ready  out  1  stage 0 can accept a beat.
- in_data  in  N*W  lane i occupies bits [i*W +: W].
- out_valid  out  1  output beat present.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  N*W  permuted lanes, same packing as in_data.

## Operation
- Stage s, with D = N>>(s+1), pairs lane j with lane j+D for every j whose bit log2(D) is 0. Elements are numbered e = 0.. in ascending j.
- Element function:
  - sel=0 passes: lo→lo, hi→hi.
  - sel=1 swaps: lo→hi, hi→lo.
- Active select register (sel_act):
  - Reset value is 0, giving identity routing.
  - On cfg_valid it takes cfg_sel at the clock edge.
- A beat accepted (in_valid & in_ready) captures the current sel_act value, not the value being written that cycle. Its select bits are carried down the pipeline with the data.
- When cfg_valid and beat acceptance occur in the same cycle, the accepted beat uses the old config. The next accepted beat uses the new one.
- Each stage holds a valid bit, N*W data bits and the select bits for the remaining stages.
- Handshake: stage s may load when it is empty or when its contents are moving on in the same cycle.
  - The last stage moves when out_ready is high.
  - in_ready = !v[0] | ready_into_stage1.
  - The ready chain is combinational from out_ready.
- in_data is ignored when in_valid is low. out_data is undefined when out_valid is low.
- Reset values:
  - in_ready=1, out_valid=0, all stage valid bits 0, sel_act=0.
  - Data registers need not be reset.

## Timing
- Latency: a beat accepted at edge k presents out_valid=1 after edge k+LOG2N−1, i.e. LOG2N register stages.
- Throughput is one beat per cycle while out_ready=1.
- Full: all LOG2N stages valid and out_ready=0 gives in_ready=0 in that same cycle.
- Bubbles collapse: a downstream stall does not block upstream stages until they reach a full stage.
- Reset mid-operation discards all in-flight beats. out_valid=0 and sel_act=0 from the first cycle after reset is sampled high.
- A beat must never be lost or duplicated. out_data must stay stable while out_valid=1 and out_ready=0.

## Configuration
- Macro: SWNET_PERF_EN.
- Defined: adds two ports.
  - beat_count  out  16: output transfers (out_valid & out_ready).
  - stall_count  out  16: cycles with out_valid & !out_ready.
  - Both counters saturate at 0xFFFF and are cleared by reset.
- Undefined: neither the ports nor the counters exist. Datapath behaviour is identical in both builds.

## Structure
- Package swnet_pkg holds:
  - the default LOG2N and W constants;
  - a function partner(stage, lane) returning the paired lane;
  - a function sel_index(stage, elem) returning the cfg_sel bit index.
- Sub-module swnet_stage, parametrised by stage index, LOG2N and W. It contains the N/2 elements of one stage plus that stage's valid/data/select register and its ready logic.
- swnet_pipe instantiates LOG2N swnet_stage copies, plus sel_act and the optional counters.

## Test plan
All scenarios use LOG2N=2, W=8 unless stated.
1. Reset: hold reset 2 cycles → in_ready=1, out_valid=0. A following beat with lanes0..3 = 00,11,22,33 and no config emerges 2 cycles later unchanged.
2. Stage-0 swap: cfg_sel=4'b0011, input 00,11,22,33 → output 22,33,00,11.
3. Full config: cfg_sel=4'b1111, input 00,11,22,33 → output 33,22,11,00.
4. Backpressure: stream 8 beats 0x00..0x07 (all lanes) while holding out_ready=0 for cycles 3–7.
   - in_ready drops once 2 beats are held.
   - Output order is exactly 0x00..0x07, with no drops or duplicates.
   - out_data is stable during the stall.
5. Config race: drive cfg_valid with 4'b0011 in the same cycle beat A is accepted, then send beat B. A is passed through unchanged and B is swapped. Sweep LOG2N=3 with random cfg_sel against a reference model.
6. Reset mid-stream: assert reset with 2 beats in flight → out_valid=0 next cycle, the beats never appear, and sel_act returns to identity. With SWNET_PERF_EN defined, beat_count and stall_count read 0.

Source files
------------

// File: rtl/swnet_pkg.sv
// Shared constants and lane-pairing helpers for the swnet butterfly switch.
// The optional performance counters in swnet_pipe are enabled by SWNET_PERF_EN.
package swnet_pkg;

  localparam int LOG2N_DEF = 2;
  localparam int W_DEF     = 8;

  // Lane paired with `lane` in stage `stage`: lanes differ only in the bit
  // whose weight is D = N >> (stage+1).
  function automatic int partner(input int stage, input int lane,
                                 input int log2n = LOG2N_DEF);
    return lane ^ ((1 << log2n) >> (stage + 1));
  endfunction

  // Bit of the flattened select vector that drives element `elem` of `stage`.
  function automatic int sel_index(input int stage, input int elem,
                                   input int log2n = LOG2N_DEF);
    return stage * ((1 << log2n) / 2) + elem;
  endfunction

  // Element number owning `lane` in `stage`; elements are counted in
  // ascending order of their low lane, so the D-weight bit is squeezed out.
  function automatic int elem_of(input int stage, input int lane,
                                 input int log2n = LOG2N_DEF);
    int d;
    d = (1 << log2n) >> (stage + 1);
    return ((lane / (2 * d)) * d) + (lane % d);
  endfunction

endpackage

// File: rtl/swnet_stage.sv
// One registered butterfly stage: N/2 pass/swap elements feeding a
// valid/data/select register with elastic (skid-free) ready logic.
module swnet_stage
  import swnet_pkg::*;
#(
  parameter int STAGE = 0,
  parameter int LOG2N = LOG2N_DEF,
  parameter int W     = W_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              up_valid,
  output logic                              up_ready,
  input  logic [(1<<LOG2N)*W-1:0]           up_data,
  input  logic [LOG2N*(1<<LOG2N)/2-1:0]     up_sel,
  output logic                              dn_valid,
  input  logic                              dn_ready,
  output logic [(1<<LOG2N)*W-1:0]           dn_data,
  output logic [LOG2N*(1<<LOG2N)/2-1:0]     dn_sel
);

  localparam int N    = 1 << LOG2N;
  localparam int NW   = N * W;
  localparam int SELW = LOG2N * N / 2;

  logic            v_q, v_d;
  logic [NW-1:0]   data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NW-1:0]   routed;
  logic            load;

  // The stage can take a beat when empty or when its beat leaves this cycle.
  assign up_ready = !v_q | dn_ready;
  assign load     = up_valid & up_ready;

  // Each lane picks its own input (pass) or its partner's (swap); both lanes
  // of an element share the same select bit, so this is a 2x2 crossbar.
  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam int P  = partner(STAGE, j, LOG2N);
    localparam int SI = sel_index(STAGE, elem_of(STAGE, j, LOG2N), LOG2N);
    assign routed[j*W +: W] = up_sel[SI] ? up_data[P*W +: W] : up_data[j*W +: W];
  end

  // Next-state for the stage register: load, drain, or hold.
  // The full select vector travels along; bits of stages already passed
  // are dead downstream and get trimmed by synthesis.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    sel_d  = sel_q;
    if (load) begin
      v_d    = 1'b1;
      data_d = routed;
      sel_d  = up_sel;
    end else if (dn_ready) begin
      v_d    = 1'b0;
    end
  end

  // Valid bit is the only state that needs reset.
  always_ff @(posedge clk) begin
    if (reset) v_q <= 1'b0;
    else       v_q <= v_d;
  end

  // Payload registers; contents are don't-care while v_q is low.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    sel_q  <= sel_d;
  end

  assign dn_valid = v_q;
  assign dn_data  = data_q;
  assign dn_sel   = sel_q;

endmodule

// File: rtl/swnet_pipe.sv
// Pipelined N x N butterfly lane permuter, LOG2N registered stages.
// Optional beat/stall counters are compiled in when SWNET_PERF_EN is defined.
//
// Handshake: a beat transfers on any rising edge where valid and ready are
// both high; valid never waits on ready, ready may depend combinationally on
// the downstream ready (the ready chain runs from out_ready to in_ready).
module swnet_pipe
  import swnet_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF,
  parameter int W     = W_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_valid,
  input  logic [LOG2N*(1<<LOG2N)/2-1:0] cfg_sel,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [(1<<LOG2N)*W-1:0]       in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
`ifdef SWNET_PERF_EN
  output logic [15:0]                   beat_count,
  output logic [15:0]                   stall_count,
`endif
  output logic [(1<<LOG2N)*W-1:0]       out_data
);

  localparam int N    = 1 << LOG2N;
  localparam int NW   = N * W;
  localparam int SELW = LOG2N * N / 2;

  logic [SELW-1:0] sel_act_q, sel_act_d;
  logic            unused_sel;

  // Beats sample sel_act_q, so a config written this cycle only affects
  // beats accepted on later edges.
  always_comb begin
    sel_act_d = sel_act_q;
    if (cfg_valid) sel_act_d = cfg_sel;
  end

  // Active select register; identity routing after reset.
  always_ff @(posedge clk) begin
    if (reset) sel_act_q <= '0;
    else       sel_act_q <= sel_act_d;
  end

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    logic            up_valid, up_ready, dn_valid, dn_ready;
    logic [NW-1:0]   up_data, dn_data;
    logic [SELW-1:0] up_sel, dn_sel;

    if (s == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_data  = in_data;
      assign up_sel   = sel_act_q;
    end else begin : g_chain
      assign up_valid = g_stage[s-1].dn_valid;
      assign up_data  = g_stage[s-1].dn_data;
      assign up_sel   = g_stage[s-1].dn_sel;
    end

    if (s == LOG2N - 1) begin : g_last
      assign dn_ready = out_ready;
    end else begin : g_inner
      assign dn_ready = g_stage[s+1].up_ready;
    end

    swnet_stage #(
      .STAGE (s),
      .LOG2N (LOG2N),
      .W     (W)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .up_valid (up_valid),
      .up_ready (up_ready),
      .up_data  (up_data),
      .up_sel   (up_sel),
      .dn_valid (dn_valid),
      .dn_ready (dn_ready),
      .dn_data  (dn_data),
      .dn_sel   (dn_sel)
    );
  end

  assign in_ready   = g_stage[0].up_ready;
  assign out_valid  = g_stage[LOG2N-1].dn_valid;
  assign out_data   = g_stage[LOG2N-1].dn_data;
  // Selects leaving the last stage have no consumer.
  assign unused_sel = ^g_stage[LOG2N-1].dn_sel;

`ifdef SWNET_PERF_EN
  logic [15:0] beat_count_q, beat_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  // Saturating transfer and stall counters on the output port.
  always_comb begin
    beat_count_d  = beat_count_q;
    stall_count_d = stall_count_q;
    if (out_valid && out_ready && beat_count_q != 16'hFFFF)
      beat_count_d = beat_count_q + 16'd1;
    if (out_valid && !out_ready && stall_count_q != 16'hFFFF)
      stall_count_d = stall_count_q + 16'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      beat_count_q  <= beat_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign beat_count  = beat_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
